// File: rtl/cpu5_pipe_ctrl_pkg.sv
// rtl/cpu5_pipe_ctrl_pkg.sv - shared widths and pipeline-case selection for the cpu5 sequencer
package cpu5_pipe_ctrl_pkg;

    localparam int CPU5_RFIDX_WIDTH = 5;
    localparam int CPU5_STALL_CW    = 32;

    typedef enum logic [1:0] {
        PC_NORMAL    = 2'd0,
        PC_LU_HAZ    = 2'd1,
        PC_FLUSH     = 2'd2,
        PC_MEM_STALL = 2'd3
    } pipe_case_e;

    // MEM back-pressure outranks a flush, and a flush squashes the hazarding ID instruction.
    function automatic pipe_case_e pipe_case_sel(input logic mem_stall,
                                                 input logic flush,
                                                 input logic lu_haz);
        if (mem_stall)   return PC_MEM_STALL;
        else if (flush)  return PC_FLUSH;
        else if (lu_haz) return PC_LU_HAZ;
        else             return PC_NORMAL;
    endfunction

endpackage

// File: rtl/cpu5_dffr.sv
// rtl/cpu5_dffr.sv - flop bank with asynchronous active-high clear
module cpu5_dffr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_o <= '0;
        else     q_o <= d_i;
    end

endmodule

// File: rtl/cpu5_hazard_det.sv
// rtl/cpu5_hazard_det.sv - load-use hazard compare between the EX load and the ID source operands
module cpu5_hazard_det
    import cpu5_pipe_ctrl_pkg::*;
#(
    parameter int RW = CPU5_RFIDX_WIDTH
) (
    input  logic          ex_vld_i,
    input  logic          ex_is_load_i,
    input  logic          ex_rd_wen_i,
    input  logic [RW-1:0] ex_rd_addr_i,
    input  logic          id_vld_i,
    input  logic          id_rs1_used_i,
    input  logic [RW-1:0] id_rs1_addr_i,
    input  logic          id_rs2_used_i,
    input  logic [RW-1:0] id_rs2_addr_i,
    output logic          lu_haz_o
);

    logic ex_load_wr;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired, so a load targeting it never creates a dependency.
    assign ex_load_wr = ex_vld_i & ex_is_load_i & ex_rd_wen_i & (ex_rd_addr_i != '0);
    assign rs1_hit    = id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_hit    = id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i);
    assign lu_haz_o   = ex_load_wr & id_vld_i & (rs1_hit | rs2_hit);

endmodule

// File: rtl/cpu5_pipe_ctrl.sv
// rtl/cpu5_pipe_ctrl.sv - cpu5 pipeline sequencer: stage valids, register load-enables, stall counter
module cpu5_pipe_ctrl
    import cpu5_pipe_ctrl_pkg::*;
#(
    parameter int RW       = CPU5_RFIDX_WIDTH,
    parameter int STALL_CW = CPU5_STALL_CW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_vld_i,
    input  logic                id_rs1_used,
    input  logic [RW-1:0]       id_rs1_addr,
    input  logic                id_rs2_used,
    input  logic [RW-1:0]       id_rs2_addr,
    input  logic                ex_is_load,
    input  logic                ex_rd_wen,
    input  logic [RW-1:0]       ex_rd_addr,
    input  logic                ex_bjp_taken,
    input  logic                mem_busy,
    input  logic                stall_cnt_clr,
    output logic                pc_lden,
    output logic                ifid_lden,
    output logic                idex_lden,
    output logic                exmem_lden,
    output logic                memwb_lden,
    output logic                id_vld,
    output logic                ex_vld,
    output logic                mem_vld,
    output logic                wb_vld,
    output logic [STALL_CW-1:0] stall_cnt
);

    logic                mem_stall;
    logic                flush;
    logic                lu_haz;
    pipe_case_e          pcase;
    logic [3:0]          vld_q;
    logic [3:0]          vld_d;
    logic                stall_inc;
    logic [STALL_CW-1:0] cnt_q;
    logic [STALL_CW-1:0] cnt_d;

    assign {id_vld, ex_vld, mem_vld, wb_vld} = vld_q;
    assign stall_cnt = cnt_q;

    cpu5_hazard_det #(.RW(RW)) u_hazard_det (
        .ex_vld_i      (ex_vld),
        .ex_is_load_i  (ex_is_load),
        .ex_rd_wen_i   (ex_rd_wen),
        .ex_rd_addr_i  (ex_rd_addr),
        .id_vld_i      (id_vld),
        .id_rs1_used_i (id_rs1_used),
        .id_rs1_addr_i (id_rs1_addr),
        .id_rs2_used_i (id_rs2_used),
        .id_rs2_addr_i (id_rs2_addr),
        .lu_haz_o      (lu_haz)
    );

    assign mem_stall = mem_vld & mem_busy;
    assign flush     = ex_vld & ex_bjp_taken;
    assign pcase     = pipe_case_sel(mem_stall, flush, lu_haz);

    assign pc_lden    = (pcase != PC_MEM_STALL) & (pcase != PC_LU_HAZ);
    assign ifid_lden  = (pcase != PC_MEM_STALL) & (pcase != PC_LU_HAZ);
    assign idex_lden  = (pcase != PC_MEM_STALL);
    assign exmem_lden = (pcase != PC_MEM_STALL);
    assign memwb_lden = 1'b1;

    // A stalled MEM keeps its instruction, so WB receives a bubble; a flushed branch still retires.
    assign vld_d = (pcase == PC_MEM_STALL) ? {id_vld, ex_vld, mem_vld, 1'b0}   :
                   (pcase == PC_FLUSH)     ? {1'b0, 1'b0, 1'b1, mem_vld}       :
                   (pcase == PC_LU_HAZ)    ? {id_vld, 1'b0, ex_vld, mem_vld}   :
                                             {if_vld_i, id_vld, ex_vld, mem_vld};

    assign stall_inc = (pcase == PC_MEM_STALL) | (pcase == PC_LU_HAZ);
    assign cnt_d     = stall_cnt_clr               ? '0 :
                       (stall_inc && !(&cnt_q))    ? cnt_q + {{(STALL_CW-1){1'b0}}, 1'b1} :
                                                     cnt_q;

    cpu5_dffr #(.W(4)) u_vld_ff (
        .clk (clk),
        .rst (rst),
        .d_i (vld_d),
        .q_o (vld_q)
    );

    cpu5_dffr #(.W(STALL_CW)) u_cnt_ff (
        .clk (clk),
        .rst (rst),
        .d_i (cnt_d),
        .q_o (cnt_q)
    );

endmodule

// File: tb/tb_cpu5_pipe_ctrl.sv
// tb/tb_cpu5_pipe_ctrl.sv - scoreboard bench for the cpu5 pipeline sequencer
module tb_cpu5_pipe_ctrl;

    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_vld_i;
    logic          id_rs1_used, id_rs2_used;
    logic [RW-1:0] id_rs1_addr, id_rs2_addr;
    logic          ex_is_load, ex_rd_wen, ex_bjp_taken;
    logic [RW-1:0] ex_rd_addr;
    logic          mem_busy, stall_cnt_clr;
    logic          pc_lden, ifid_lden, idex_lden, exmem_lden, memwb_lden;
    logic          id_vld, ex_vld, mem_vld, wb_vld;
    logic [CW-1:0] stall_cnt;

    typedef struct {
        string      nm;
        logic [4:0] lden;
        logic [3:0] vld;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cpu5_pipe_ctrl #(.RW(RW), .STALL_CW(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_vld_i      (if_vld_i),
        .id_rs1_used   (id_rs1_used),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_used   (id_rs2_used),
        .id_rs2_addr   (id_rs2_addr),
        .ex_is_load    (ex_is_load),
        .ex_rd_wen     (ex_rd_wen),
        .ex_rd_addr    (ex_rd_addr),
        .ex_bjp_taken  (ex_bjp_taken),
        .mem_busy      (mem_busy),
        .stall_cnt_clr (stall_cnt_clr),
        .pc_lden       (pc_lden),
        .ifid_lden     (ifid_lden),
        .idex_lden     (idex_lden),
        .exmem_lden    (exmem_lden),
        .memwb_lden    (memwb_lden),
        .id_vld        (id_vld),
        .ex_vld        (ex_vld),
        .mem_vld       (mem_vld),
        .wb_vld        (wb_vld),
        .stall_cnt     (stall_cnt)
    );

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [4:0] al;
            logic [3:0] av;
            e  = sb.pop_front();
            al = {pc_lden, ifid_lden, idex_lden, exmem_lden, memwb_lden};
            av = {id_vld, ex_vld, mem_vld, wb_vld};
            n_chk = n_chk + 3;
            if (al !== e.lden) begin
                n_fail = n_fail + 1;
                $display("FAIL %s lden: got %b expected %b", e.nm, al, e.lden);
            end
            if (av !== e.vld) begin
                n_fail = n_fail + 1;
                $display("FAIL %s vld: got %b expected %b", e.nm, av, e.vld);
            end
            if (stall_cnt !== e.cnt) begin
                n_fail = n_fail + 1;
                $display("FAIL %s stall_cnt: got %0d expected %0d", e.nm, stall_cnt, e.cnt);
            end
        end
    end

    task automatic idle_inputs();
        if_vld_i      = 1'b0;
        id_rs1_used   = 1'b0;
        id_rs1_addr   = '0;
        id_rs2_used   = 1'b0;
        id_rs2_addr   = '0;
        ex_is_load    = 1'b0;
        ex_rd_wen     = 1'b0;
        ex_rd_addr    = '0;
        ex_bjp_taken  = 1'b0;
        mem_busy      = 1'b0;
        stall_cnt_clr = 1'b0;
    endtask

    task automatic load_rd(input logic [RW-1:0] rd);
        ex_is_load = 1'b1;
        ex_rd_wen  = 1'b1;
        ex_rd_addr = rd;
    endtask

    // Inputs are already applied; queue what the monitor must see this cycle, then advance.
    task automatic cyc(input string nm, input logic [4:0] el, input logic [3:0] ev, input logic [3:0] ec);
        exp_t e;
        e.nm = nm; e.lden = el; e.vld = ev; e.cnt = ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 5'b11111, 4'b0000, 4'd0);
        rst = 1'b0;

        if_vld_i = 1'b1;
        cyc("fill1", 5'b11111, 4'b0000, 4'd0);
        cyc("fill2", 5'b11111, 4'b1000, 4'd0);
        cyc("fill3", 5'b11111, 4'b1100, 4'd0);
        cyc("fill4", 5'b11111, 4'b1110, 4'd0);
        cyc("full",  5'b11111, 4'b1111, 4'd0);

        load_rd(5'd5); id_rs1_used = 1'b1; id_rs1_addr = 5'd5;
        cyc("luhaz_rs1", 5'b00111, 4'b1111, 4'd0);
        idle_inputs(); if_vld_i = 1'b1;
        cyc("after_luhaz", 5'b11111, 4'b1011, 4'd1);

        load_rd(5'd0); id_rs1_used = 1'b1; id_rs1_addr = 5'd0;
        cyc("rd_x0", 5'b11111, 4'b1101, 4'd1);
        load_rd(5'd5); id_rs1_used = 1'b0; id_rs1_addr = 5'd5;
        cyc("rs1_unused", 5'b11111, 4'b1110, 4'd1);
        id_rs2_used = 1'b1; id_rs2_addr = 5'd5;
        cyc("luhaz_rs2", 5'b00111, 4'b1111, 4'd1);
        idle_inputs(); if_vld_i = 1'b1;
        cyc("refill1", 5'b11111, 4'b1011, 4'd2);
        cyc("refill2", 5'b11111, 4'b1101, 4'd2);
        cyc("refill3", 5'b11111, 4'b1110, 4'd2);

        load_rd(5'd5); id_rs1_used = 1'b1; id_rs1_addr = 5'd5; ex_bjp_taken = 1'b1;
        cyc("flush_over_haz", 5'b11111, 4'b1111, 4'd2);
        idle_inputs(); if_vld_i = 1'b1;
        cyc("post_flush", 5'b11111, 4'b0011, 4'd2);
        ex_bjp_taken = 1'b1;
        cyc("bjp_ex_invalid", 5'b11111, 4'b1001, 4'd2);
        ex_bjp_taken = 1'b0;
        cyc("refill4", 5'b11111, 4'b1100, 4'd2);
        cyc("refill5", 5'b11111, 4'b1110, 4'd2);

        mem_busy = 1'b1; ex_bjp_taken = 1'b1;
        cyc("mstall1", 5'b00001, 4'b1111, 4'd2);
        cyc("mstall2", 5'b00001, 4'b1110, 4'd3);
        cyc("mstall3", 5'b00001, 4'b1110, 4'd4);
        mem_busy = 1'b0;
        cyc("held_flush", 5'b11111, 4'b1110, 4'd5);
        ex_bjp_taken = 1'b0;
        cyc("post_hflush", 5'b11111, 4'b0011, 4'd5);
        cyc("refill6", 5'b11111, 4'b1001, 4'd5);
        cyc("refill7", 5'b11111, 4'b1100, 4'd5);

        mem_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int c;
            c = (5 + i > 15) ? 15 : 5 + i;
            cyc($sformatf("sat%0d", i), 5'b00001, 4'b1110, 4'(c));
        end
        stall_cnt_clr = 1'b1;
        cyc("clr_wins", 5'b00001, 4'b1110, 4'd15);
        stall_cnt_clr = 1'b0;
        cyc("after_clr", 5'b00001, 4'b1110, 4'd0);
        rst = 1'b1;
        cyc("async_rst", 5'b11111, 4'b0000, 4'd0);
        rst = 1'b0; idle_inputs();
        cyc("post_rst", 5'b11111, 4'b0000, 4'd0);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            n_chk  = n_chk + 1;
            n_fail = n_fail + 1;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
